// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, parity modes and sizing helper
package uart_pkg;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count
);
  localparam int AW = cnt_w(DEPTH) - 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  // a pop frees the slot the simultaneous push needs when full
  always_comb begin
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    count = wp - rp;
    dout = mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: oversampled UART receiver feeding a FWFT FIFO with error pulses
module uart_rx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int OVERSAMPLE      = 16,
  parameter int CLKS_PER_SAMPLE = 4,
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         RX_bit,
  input  logic                         RD_EN,
  output logic [DATA_BITS-1:0]         RX_data,
  output logic                         RX_valid,
  output logic                         FIFO_full,
  output logic [cnt_w(FIFO_DEPTH)-1:0] FIFO_count,
  output logic                         FRAME_ERR,
  output logic                         PARITY_ERR,
  output logic                         OVERRUN
);
  localparam logic [1:0] PAR_MODE = PARITY_EN == 0 ? PAR_NONE : (PARITY_ODD != 0 ? PAR_ODD : PAR_EVEN);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int DW = CLKS_PER_SAMPLE > 1 ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [DW-1:0] D_END = DW'(CLKS_PER_SAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);
  logic s1, rx;
  logic [2:0] st;
  logic [SW-1:0] scnt;
  logic [DW-1:0] div;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] sh;
  logic par_bad, tick, at_end, stop_smp, good, empty, pop, push;
  always_comb begin
    tick = div == D_END;
    at_end = tick && scnt == S_END;
    stop_smp = st == ST_STOP && at_end;
    good = stop_smp && rx && !par_bad;
    pop = RD_EN && !empty;
    push = good && (!FIFO_full || pop);
    RX_valid = !empty;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1 <= 1'b1;
      rx <= 1'b1;
      st <= ST_IDLE;
      div <= '0;
      scnt <= '0;
      bcnt <= '0;
      par_bad <= 1'b0;
      FRAME_ERR <= 1'b0;
      PARITY_ERR <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      s1 <= RX_bit;
      rx <= s1;
      div <= (tick || (st == ST_IDLE && !rx)) ? '0 : div + 1'b1;
      if (tick && st != ST_IDLE && st != ST_WAIT_IDLE) scnt <= at_end ? '0 : scnt + 1'b1;
      FRAME_ERR <= stop_smp && !rx;
      PARITY_ERR <= stop_smp && rx && par_bad;
      OVERRUN <= good && FIFO_full && !pop;
      case (st)
        ST_IDLE: if (!rx) begin
          st <= ST_START;
          scnt <= '0;
          bcnt <= '0;
          par_bad <= 1'b0;
        end
        ST_START: if (tick && scnt == S_MID) begin
          st <= rx ? ST_IDLE : ST_DATA;
          scnt <= '0;
        end
        ST_DATA: if (at_end) begin
          sh <= {rx, sh[DATA_BITS-1:1]};
          bcnt <= bcnt + 1'b1;
          if (bcnt == B_END) st <= PAR_MODE == PAR_NONE ? ST_STOP : ST_PARITY;
        end
        ST_PARITY: if (at_end) begin
          par_bad <= rx != (^sh ^ (PAR_MODE == PAR_ODD));
          st <= ST_STOP;
        end
        ST_STOP: if (at_end) st <= rx ? ST_IDLE : ST_WAIT_IDLE;
        default: if (rx) st <= ST_IDLE;
      endcase
    end
  end
  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK),
    .rst_n(RST_N),
    .push(push),
    .pop(pop),
    .din(sh),
    .dout(RX_data),
    .full(FIFO_full),
    .empty(empty),
    .count(FIFO_count)
  );
endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// tb_uart_rx_fifo_param: directed checks of the UART receiver (8N1 depth 4, 8E1 depth 8)
module tb_uart_rx_fifo_param;
  logic clk = 1'b0, rst_n = 1'b0, rx_a = 1'b1, rx_b = 1'b1, rd_a = 1'b0, rd_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic val_a, val_b, full_a, full_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
  logic [2:0] cnt_a;
  logic [3:0] cnt_b;
  int checks = 0, errors = 0;
  int n_fe_a = 0, n_pe_a = 0, n_ov_a = 0, n_fe_b = 0, n_pe_b = 0, n_ov_b = 0;
  int s_fe, s_pe, s_ov;
  always #5 clk = ~clk;
  uart_rx_fifo_param #(.FIFO_DEPTH(4)) dut_a (
    .CLK(clk), .RST_N(rst_n), .RX_bit(rx_a), .RD_EN(rd_a), .RX_data(data_a), .RX_valid(val_a),
    .FIFO_full(full_a), .FIFO_count(cnt_a), .FRAME_ERR(fe_a), .PARITY_ERR(pe_a), .OVERRUN(ov_a)
  );
  uart_rx_fifo_param #(.PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(8)) dut_b (
    .CLK(clk), .RST_N(rst_n), .RX_bit(rx_b), .RD_EN(rd_b), .RX_data(data_b), .RX_valid(val_b),
    .FIFO_full(full_b), .FIFO_count(cnt_b), .FRAME_ERR(fe_b), .PARITY_ERR(pe_b), .OVERRUN(ov_b)
  );
  always @(negedge clk) begin
    if (fe_a) n_fe_a++;
    if (pe_a) n_pe_a++;
    if (ov_a) n_ov_a++;
    if (fe_b) n_fe_b++;
    if (pe_b) n_pe_b++;
    if (ov_b) n_ov_b++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // each bit held 64 clocks (16 ticks x 4 clocks), LSB of bits first
  task automatic send_a(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_a = bits[i];
      repeat (64) @(negedge clk);
    end
  endtask
  task automatic send_b(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_b = bits[i];
      repeat (64) @(negedge clk);
    end
  endtask
  task automatic pop_a();
    rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
  endtask
  function automatic logic [15:0] fr(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction
  initial begin
    repeat (5) @(negedge clk);
    chk("rst_valid_a", val_a, 0);
    chk("rst_full_a", full_a, 0);
    chk("rst_count_a", cnt_a, 0);
    chk("rst_errs_a", {fe_a, pe_a, ov_a}, 0);
    chk("rst_valid_b", val_b, 0);
    chk("rst_count_b", cnt_b, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    // basic 8N1: stop sampled 611 clocks after the start edge
    send_a({7'b0, 8'hA5, 1'b0}, 9);
    rx_a = 1'b1;
    repeat (34) @(negedge clk);
    chk("basic_before_push", val_a, 0);
    @(negedge clk);
    chk("basic_valid", val_a, 1);
    chk("basic_data", data_a, 8'hA5);
    chk("basic_count", cnt_a, 1);
    repeat (40) @(negedge clk);
    pop_a();
    chk("basic_pop_valid", val_a, 0);
    chk("basic_pop_count", cnt_a, 0);
    // false start glitch
    s_fe = n_fe_a; s_pe = n_pe_a; s_ov = n_ov_a;
    rx_a = 1'b0;
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    repeat (200) @(negedge clk);
    chk("false_count", cnt_a, 0);
    chk("false_valid", val_a, 0);
    chk("false_errs", n_fe_a + n_pe_a + n_ov_a - s_fe - s_pe - s_ov, 0);
    // framing error with break, then a good frame
    s_fe = n_fe_a;
    send_a({7'b0, 8'h3C, 1'b0}, 9);
    rx_a = 1'b0;
    repeat (300) @(negedge clk);
    rx_a = 1'b1;
    repeat (100) @(negedge clk);
    chk("frame_err_pulses", n_fe_a - s_fe, 1);
    chk("frame_no_push", cnt_a, 0);
    chk("frame_no_parity", n_pe_a - s_pe, 0);
    send_a(fr(8'h11), 10);
    repeat (20) @(negedge clk);
    chk("after_break_valid", val_a, 1);
    chk("after_break_data", data_a, 8'h11);
    chk("after_break_fe", n_fe_a - s_fe, 1);
    pop_a();
    // fill depth-4 FIFO then overrun
    for (int i = 0; i < 4; i++) begin
      send_a(fr(8'(i + 1)), 10);
      chk("fill_count", cnt_a, i + 1);
      chk("fill_full", full_a, i == 3);
    end
    s_ov = n_ov_a;
    send_a(fr(8'h05), 10);
    repeat (5) @(negedge clk);
    chk("overrun_pulses", n_ov_a - s_ov, 1);
    chk("overrun_count", cnt_a, 4);
    for (int i = 0; i < 4; i++) begin
      chk("read_order", data_a, i + 1);
      pop_a();
    end
    chk("drained_valid", val_a, 0);
    pop_a();
    chk("empty_pop_count", cnt_a, 0);
    // full FIFO with a pop on the stop-sample cycle
    for (int i = 0; i < 4; i++) send_a(fr(8'(8'h21 + i)), 10);
    s_ov = n_ov_a;
    send_a({7'b0, 8'h25, 1'b0}, 9);
    rx_a = 1'b1;
    repeat (34) @(negedge clk);
    rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
    chk("simul_count", cnt_a, 4);
    chk("simul_full", full_a, 1);
    chk("simul_head", data_a, 8'h22);
    repeat (40) @(negedge clk);
    chk("simul_no_overrun", n_ov_a - s_ov, 0);
    for (int i = 0; i < 4; i++) begin
      chk("simul_read", data_a, 8'h22 + i);
      pop_a();
    end
    // even parity on dut_b: 0x07 needs parity bit 1
    send_b({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (5) @(negedge clk);
    chk("parity_err_pulses", n_pe_b, 1);
    chk("parity_no_push", cnt_b, 0);
    chk("parity_no_fe", n_fe_b, 0);
    send_b({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (5) @(negedge clk);
    chk("parity_ok_valid", val_b, 1);
    chk("parity_ok_data", data_b, 8'h07);
    chk("parity_ok_pe", n_pe_b, 1);
    // reset mid-DATA with a word buffered
    send_a(fr(8'h5A), 10);
    repeat (5) @(negedge clk);
    chk("pre_reset_count", cnt_a, 1);
    s_fe = n_fe_a; s_pe = n_pe_a; s_ov = n_ov_a;
    send_a({7'b0, 8'hC3, 1'b0}, 4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", val_a, 0);
    chk("midrst_count", cnt_a, 0);
    chk("midrst_full", full_a, 0);
    chk("midrst_errs", {fe_a, pe_a, ov_a}, 0);
    chk("midrst_valid_b", val_b, 0);
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (800) @(negedge clk);
    chk("postrst_count", cnt_a, 0);
    chk("postrst_errs", n_fe_a + n_pe_a + n_ov_a - s_fe - s_pe - s_ov, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
